// File: rtl/img_pkg.sv
// Shared pixel/window types for the 3x3 window stream (producer and filter stage).
package img_pkg;

  // Pixel width used by the shared window types; matches the default DATA_BW of window_gen.
  localparam int unsigned PIX_BW  = 8;
  localparam int unsigned WIN_PIX = 9;

  typedef logic [PIX_BW-1:0]  pix_t;
  typedef pix_t [WIN_PIX-1:0] win_t;

  typedef enum logic [0:0] {
    StFill,
    StRun
  } wg_state_e;

  // Pixel i (row-major, top-left = 0) lands in the MSB end; the filter's unpack mirrors this.
  function automatic logic [PIX_BW*WIN_PIX-1:0] pack_win(input win_t w);
    logic [PIX_BW*WIN_PIX-1:0] flat;
    flat = '0;
    for (int i = 0; i < WIN_PIX; i++) begin
      flat[PIX_BW*WIN_PIX-1-i*PIX_BW -: PIX_BW] = w[i];
    end
    return flat;
  endfunction

endpackage

// File: rtl/line_buf.sv
// Single-line pixel store: synchronous write, asynchronous read of the same address.
module line_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; stale lines are overwritten before they reach a window.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read returns the old content during a write cycle (read-before-write).
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen.sv
// Raster-to-window converter: buffers two lines and emits every interior 3x3 neighbourhood.
module window_gen
  import img_pkg::*;
#(
  parameter int unsigned DATA_BW = 8,
  parameter int unsigned IMG_W   = 16,
  parameter int unsigned IMG_H   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_dxi_in_valid,
  input  logic [DATA_BW-1:0]     i_dxi_in_data,
  output logic                   o_dxi_in_ready,
  output logic                   o_dxi_out_valid,
  output logic [DATA_BW*9-1:0]   o_dxi_out_data,
  input  logic                   i_dxi_out_ready,
  output logic                   o_frame_done
);

  localparam int unsigned CW     = $clog2(IMG_W);
  localparam int unsigned RW     = $clog2(IMG_H);
  localparam int unsigned OUT_BW = DATA_BW * WIN_PIX;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  wg_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [DATA_BW-1:0] win_q [3][3];
  logic [DATA_BW-1:0] win_d [3][3];
  logic [OUT_BW-1:0]  win_flat;

  logic              out_valid_q, out_valid_d;
  logic [OUT_BW-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic [DATA_BW-1:0] lb0_rd, lb1_rd;
  logic in_accept, out_accept, win_done, pix_last;

  // A stalled window blocks intake so it can never be overwritten before it is taken.
  assign o_dxi_in_ready = !out_valid_q || i_dxi_out_ready;
  assign in_accept      = i_dxi_in_valid && o_dxi_in_ready;
  assign out_accept     = out_valid_q && i_dxi_out_ready;
  assign pix_last       = (row_q == ROW_LAST) && (col_q == COL_LAST);
  // StRun is exactly row >= 2, so this is the row>=2 && col>=2 completion test.
  assign win_done       = in_accept && (state_q == StRun) && (col_q >= COL_TWO);

  // lb0 holds the previous line, lb1 the one before; both advance on every accepted pixel.
  line_buf #(
    .DEPTH(IMG_W),
    .WIDTH(DATA_BW)
  ) u_lb0 (
    .clk_i  (i_clk),
    .we_i   (in_accept),
    .addr_i (col_q),
    .wdata_i(i_dxi_in_data),
    .rdata_o(lb0_rd)
  );

  line_buf #(
    .DEPTH(IMG_W),
    .WIDTH(DATA_BW)
  ) u_lb1 (
    .clk_i  (i_clk),
    .we_i   (in_accept),
    .addr_i (col_q),
    .wdata_i(lb0_rd),
    .rdata_o(lb1_rd)
  );

  // Raster counters and fill/run phase, advanced only by accepted pixels.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      unique case (state_q)
        StFill:  if ((row_q == ROW_ONE) && (col_q == COL_LAST)) state_d = StRun;
        StRun:   if (pix_last) state_d = StFill;
        default: state_d = StFill;
      endcase
    end
  end

  // Shift the 3x3 window left and load the new right-hand column from the line buffers.
  always_comb begin
    win_d = win_q;
    if (in_accept) begin
      win_d[0][0] = win_q[0][1];
      win_d[0][1] = win_q[0][2];
      win_d[0][2] = lb1_rd;
      win_d[1][0] = win_q[1][1];
      win_d[1][1] = win_q[1][2];
      win_d[1][2] = lb0_rd;
      win_d[2][0] = win_q[2][1];
      win_d[2][1] = win_q[2][2];
      win_d[2][2] = i_dxi_in_data;
    end
  end

  // Row-major packing of the next window, pixel 0 in the MSBs.
  for (genvar r = 0; r < 3; r++) begin : g_pack_row
    for (genvar k = 0; k < 3; k++) begin : g_pack_col
      assign win_flat[OUT_BW-1-(3*r+k)*DATA_BW -: DATA_BW] = win_d[r][k];
    end
  end

  // Output register: a completed window replaces the current one, otherwise hold until taken.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_accept) begin
      out_valid_d = 1'b0;
    end
    if (win_done) begin
      out_valid_d = 1'b1;
      out_data_d  = win_flat;
      out_last_d  = pix_last;
    end
  end

  // Control and output state; reset overrides every other event.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StFill;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Window pixels need no reset: every emitted window is fully reloaded from fresh pixels.
  always_ff @(posedge i_clk) begin
    win_q <= win_d;
  end

  assign o_dxi_out_valid = out_valid_q;
  assign o_dxi_out_data  = out_data_q;
  assign o_frame_done    = out_accept && out_last_q;

endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen on a 4x4 image of 8-bit pixels.
module tb_window_gen;

  localparam int unsigned BW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned OB = BW * 9;
  localparam int unsigned RB = $clog2(H);
  localparam int unsigned CB = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [OB-1:0] out_data;
  logic          out_ready = 1'b1;
  logic          frame_done;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [OB-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q [$];
  logic [OB-1:0] got_q [$];
  logic [BW-1:0] m_img [H][W];
  logic [RB-1:0] m_row = '0;
  logic [CB-1:0] m_col = '0;
  int            n_fd = 0;
  logic          prev_stall = 1'b0;
  logic [OB-1:0] prev_data = '0;

  window_gen #(
    .DATA_BW(BW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_dxi_in_valid (in_valid),
    .i_dxi_in_data  (in_data),
    .o_dxi_in_ready (in_ready),
    .o_dxi_out_valid(out_valid),
    .o_dxi_out_data (out_data),
    .i_dxi_out_ready(out_ready),
    .o_frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // Monitor: reference image model on input accepts, scoreboard pop on output handshakes.
  always @(negedge clk) begin
    exp_t          e;
    logic          fd_exp;
    logic [RB-1:0] r1, r2;
    logic [CB-1:0] c1, c2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          tests_failed++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h",
                   out_valid, out_data, prev_data);
        end
      end
      fd_exp = 1'b0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_q.push_back(out_data);
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL window: got %h, required no window", out_data);
        end else begin
          e      = exp_q.pop_front();
          fd_exp = e.last;
          if (out_data !== e.data) begin
            tests_failed++;
            $display("FAIL window: got %h, required %h", out_data, e.data);
          end
        end
      end
      tests_run++;
      if (frame_done !== fd_exp) begin
        tests_failed++;
        $display("FAIL frame_done: got %b, required %b", frame_done, fd_exp);
      end
      if (frame_done === 1'b1) n_fd++;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        m_img[m_row][m_col] = in_data;
        if (m_row >= RB'(2) && m_col >= CB'(2)) begin
          r1 = m_row - RB'(1);
          r2 = m_row - RB'(2);
          c1 = m_col - CB'(1);
          c2 = m_col - CB'(2);
          e.data = {m_img[r2][c2], m_img[r2][c1], m_img[r2][m_col],
                    m_img[r1][c2], m_img[r1][c1], m_img[r1][m_col],
                    m_img[m_row][c2], m_img[m_row][c1], m_img[m_row][m_col]};
          e.last = (m_row == RB'(H - 1)) && (m_col == CB'(W - 1));
          exp_q.push_back(e);
        end
        if (m_col == CB'(W - 1)) begin
          m_col = '0;
          m_row = (m_row == RB'(H - 1)) ? '0 : m_row + RB'(1);
        end else begin
          m_col = m_col + CB'(1);
        end
      end
      prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel (after optional random idle cycles) and wait until it is accepted.
  task automatic send_pixel(input logic [BW-1:0] p, input int gap_pct);
    int guard;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = p;
    guard    = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
    end
    tick();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      tick();
      g++;
    end
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d windows outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic model_reset();
    m_row = '0;
    m_col = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b, required 0", out_valid);
    end
    tests_run++;
    if (out_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h, required 0", out_data);
    end
    tests_run++;
    if (frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_frame_done: got %b, required 0", frame_done);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    tick();
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int w0, f0;
    w0 = got_q.size();
    f0 = n_fd;
    for (int i = 0; i < 16; i++) send_pixel(BW'(i), 0);
    in_valid = 1'b0;
    drain();
    tests_run++;
    if (got_q.size() - w0 != 4) begin
      tests_failed++;
      $display("FAIL single_count: got %0d windows, required 4", got_q.size() - w0);
    end else begin
      tests_run++;
      if (got_q[w0] !== 72'h00_01_02_04_05_06_08_09_0A) begin
        tests_failed++;
        $display("FAIL single_first: got %h, required %h", got_q[w0],
                 72'h00_01_02_04_05_06_08_09_0A);
      end
      tests_run++;
      if (got_q[w0+3] !== 72'h05_06_07_09_0A_0B_0D_0E_0F) begin
        tests_failed++;
        $display("FAIL single_last: got %h, required %h", got_q[w0+3],
                 72'h05_06_07_09_0A_0B_0D_0E_0F);
      end
    end
    tests_run++;
    if (n_fd - f0 != 1) begin
      tests_failed++;
      $display("FAIL single_frame_done: got %0d pulses, required 1", n_fd - f0);
    end
  endtask

  task automatic test_stall();
    int            w0, f0, g;
    logic [OB-1:0] held;
    w0 = got_q.size();
    f0 = n_fd;
    fork
      begin
        for (int i = 0; i < 16; i++) send_pixel(BW'(i), 0);
        in_valid = 1'b0;
      end
      begin
        g = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && g < 100) begin
          @(negedge clk);
          g++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          tests_run++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            tests_failed++;
            $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                     out_valid, out_data, held);
          end
          tests_run++;
          if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_in_ready: got %b, required 0", in_ready);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    tests_run++;
    if (got_q.size() - w0 != 4) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d windows, required 4", got_q.size() - w0);
    end
    tests_run++;
    if (n_fd - f0 != 1) begin
      tests_failed++;
      $display("FAIL stall_frame_done: got %0d pulses, required 1", n_fd - f0);
    end
  endtask

  task automatic test_back_to_back();
    int w0, f0;
    w0 = got_q.size();
    f0 = n_fd;
    for (int i = 0; i < 32; i++) send_pixel(BW'(i), 0);
    in_valid = 1'b0;
    drain();
    tests_run++;
    if (got_q.size() - w0 != 8) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d windows, required 8", got_q.size() - w0);
    end else begin
      tests_run++;
      if (got_q[w0+4] !== 72'h10_11_12_14_15_16_18_19_1A) begin
        tests_failed++;
        $display("FAIL b2b_second_first: got %h, required %h", got_q[w0+4],
                 72'h10_11_12_14_15_16_18_19_1A);
      end
    end
    tests_run++;
    if (n_fd - f0 != 2) begin
      tests_failed++;
      $display("FAIL b2b_frame_done: got %0d pulses, required 2", n_fd - f0);
    end
  endtask

  task automatic test_mid_reset();
    int w0, f0;
    for (int i = 0; i < 7; i++) send_pixel(BW'(8'h30 + i), 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: valid=%b data=%h done=%b, required all 0",
               out_valid, out_data, frame_done);
    end
    tick();
    model_reset();
    rst = 1'b0;
    w0  = got_q.size();
    f0  = n_fd;
    for (int i = 0; i < 16; i++) send_pixel(BW'(8'h20 + i), 0);
    in_valid = 1'b0;
    drain();
    tests_run++;
    if (got_q.size() - w0 != 4) begin
      tests_failed++;
      $display("FAIL midreset_count: got %0d windows, required 4", got_q.size() - w0);
    end else begin
      tests_run++;
      if (got_q[w0] !== 72'h20_21_22_24_25_26_28_29_2A) begin
        tests_failed++;
        $display("FAIL midreset_first: got %h, required %h", got_q[w0],
                 72'h20_21_22_24_25_26_28_29_2A);
      end
    end
    tests_run++;
    if (n_fd - f0 != 1) begin
      tests_failed++;
      $display("FAIL midreset_frame_done: got %0d pulses, required 1", n_fd - f0);
    end
  endtask

  task automatic test_random();
    int w0, f0;
    bit done;
    w0   = got_q.size();
    f0   = n_fd;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 160; i++) send_pixel(BW'($urandom_range(0, 255)), 50);
        in_valid = 1'b0;
        done     = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    tests_run++;
    if (got_q.size() - w0 != 40) begin
      tests_failed++;
      $display("FAIL random_count: got %0d windows, required 40", got_q.size() - w0);
    end
    tests_run++;
    if (n_fd - f0 != 10) begin
      tests_failed++;
      $display("FAIL random_frame_done: got %0d pulses, required 10", n_fd - f0);
    end
  endtask

  // Pixel k goes in on cycle k; windows from pixels 10,11,14,15 appear one cycle later.
  task automatic test_throughput();
    logic exp_v;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (cyc < 16);
      in_data  = BW'(8'h40 + cyc);
      @(negedge clk);
      exp_v = (cyc == 11) || (cyc == 12) || (cyc == 15) || (cyc == 16);
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL tput_in_ready cycle %0d: got %b, required 1", cyc, in_ready);
      end
      tests_run++;
      if (out_valid !== exp_v) begin
        tests_failed++;
        $display("FAIL tput_valid cycle %0d: got %b, required %b", cyc, out_valid, exp_v);
      end
      tick();
    end
    in_valid = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_throughput();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
